exp2_pipe: RTL
==============

Name: exp2_pipe

Overview:
- Parametrised, pipelined base-2 exponential unit for the neuron datapath: y = 2^x on signed fixed-point operands.
- Successor to the existing combinational exponent approximator. Adds:
  - full integer-part shifting, not just LSB parity;
  - an optional second-order mantissa correction;
  - saturation and underflow flags;
  - a 3-stage valid/ready pipeline.
- Sits between the membrane-potential accumulator and the activation/decay logic.

Parameters:
- IN_W, 21, input width, signed two's complement.
- FRAC, 9, fractional bits, shared by input and output.
- OUT_W, 21, output width, signed; result is always >= 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  unit can accept a sample this cycle
- in_data  in  IN_W  x, signed Q(IN_W-FRAC-1).FRAC
- in_mode  in  1  0 = linear mantissa, 1 = corrected mantissa; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  2^x, signed Q(OUT_W-FRAC-1).FRAC, non-negative
- out_sat  out  1  result saturated to max positive
- out_uflow  out  1  result flushed to zero

Behaviour:
- Reset (async, rst_n=0): all stage valids = 0, out_valid = 0, out_data = 0, out_sat = 0, out_uflow = 0. Takes effect immediately mid-operation; in-flight samples are discarded.
- Pipeline control:
  - en = out_ready | ~out_valid.
  - in_ready = en (combinational).
  - When en=1, all three stages advance together and valid bits shift with the data.
  - When en=0, every stage holds, and out_data/flags stay stable while out_valid=1.
  - No bubble compression.
- A sample is accepted on a clock edge with in_valid & in_ready.
- Latency is exactly 3 cycles from acceptance to out_valid, with no stalls. Throughput is 1 sample/cycle.
- Stage 1 (split + mantissa):
  - I = in_data >>> FRAC (arithmetic, floor); f = in_data[FRAC-1:0], unsigned.
  - p = (f * (2^FRAC - f)) >> FRAC.
  - c = (p>>2) + (p>>4) + (p>>5), an 11/32 approximation; truncating shifts.
  - m = 2^FRAC + f - (mode ? c : 0), a FRAC+1-bit unsigned value in [2^FRAC, 2^(FRAC+1)).
  - Register I, m and valid.
- Stage 2 (range classify):
  - sat = (I >= OUT_W-1-FRAC).
  - uflow = (I <= -(FRAC+1)).
  - For I >= 0 compute m << I; for I < 0 compute m >> (-I), logical and truncating.
  - Shifter width is OUT_W+1 bits internally.
  - Register shifted value, sat, uflow and valid.
- Stage 3 (output):
  - If sat: out_data = 2^(OUT_W-1)-1, out_sat = 1.
  - Else if uflow: out_data = 0, out_uflow = 1.
  - Else: out_data = shifted value, both flags 0.
  - sat and uflow are mutually exclusive.
- Simultaneous accept and drain in the same cycle is legal and loses no data.
- in_mode travels with its sample; mode changes between back-to-back samples are legal.

Test Plan:
- Reset, then in_data=512 (1.0), mode 0 -> 3 cycles later out_data=1024, no flags. Same with mode 1 -> 1024, since f=0 gives c=0.
- in_data=256 (0.5): mode 0 -> 768; mode 1 -> 724. in_data=-256 (-0.5): mode 0 -> 384; mode 1 -> 362.
- in_data=-512 -> 256. in_data=-4608 (-9.0) -> 1, no uflow. in_data=-5120 (-10.0) -> 0, out_uflow=1.
- in_data=5120 (10.0) -> 524288, no flag. in_data=5632 (11.0) -> 1048575, out_sat=1. Most negative input -> 0 with uflow.
- Stream 8 back-to-back samples with out_ready=1 -> 8 consecutive out_valid cycles with correct order and values. Then hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, outputs stable, no loss or duplication after release.
- Assert rst_n=0 asynchronously with 3 samples in flight -> out_valid drops immediately, all outputs 0. After release, the first new sample emerges after exactly 3 cycles.

Source files
------------

// File: rtl/exp2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exp2_pipe
// Purpose  : Three-stage valid/ready base-2 exponential, y = 2^x, signed
//            fixed point, with optional second-order mantissa correction.
// Revision : 1.0 - initial pipelined release
// ============================================================================
module exp2_pipe #(
    parameter int IN_W  = 21,
    parameter int FRAC  = 9,
    parameter int OUT_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_uflow
);

    localparam int c_iw = IN_W - FRAC;
    localparam int c_mw = FRAC + 1;
    localparam int c_pw = 2 * FRAC + 1;
    localparam int c_sw = OUT_W + 1;

    localparam logic signed [c_iw-1:0] c_sat_i   = c_iw'(OUT_W - 1 - FRAC);
    localparam logic signed [c_iw-1:0] c_uflow_i = c_iw'(-(FRAC + 1));
    localparam logic [c_mw-1:0]        c_one     = {1'b1, {FRAC{1'b0}}};
    localparam logic [OUT_W-1:0]       c_max     = {1'b0, {(OUT_W-1){1'b1}}};

    logic w_en;
    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1: integer/fraction split and mantissa
    // ------------------------------------------------------------------
    logic [FRAC-1:0]  w_f;
    logic [c_pw-1:0]  w_f_ext;
    logic [c_pw-1:0]  w_fc_ext;
    logic [c_mw-1:0]  w_p;
    logic [c_mw-1:0]  w_c;
    logic [c_mw-1:0]  w_m;

    assign w_f      = in_data[FRAC-1:0];
    assign w_f_ext  = c_pw'(w_f);
    assign w_fc_ext = c_pw'(c_one - c_mw'(w_f));
    assign w_p      = c_mw'((w_f_ext * w_fc_ext) >> FRAC);
    // 11/32 * f(1-f) approximates the curvature of 2^f above the chord
    assign w_c      = (w_p >> 2) + (w_p >> 4) + (w_p >> 5);
    assign w_m      = c_one + c_mw'(w_f) - (in_mode ? w_c : '0);

    logic                   r_s1_valid;
    logic signed [c_iw-1:0] r_s1_i;
    logic [c_mw-1:0]        r_s1_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_m     <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_i     <= in_data[IN_W-1:FRAC];
            r_s1_m     <= w_m;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: range classification and barrel shift
    // ------------------------------------------------------------------
    logic [c_iw-1:0] w_neg_i;
    logic [c_iw-1:0] w_shamt;
    logic [c_sw-1:0] w_m_ext;
    logic [c_sw-1:0] w_sh;
    logic            w_sat;
    logic            w_uflow;

    assign w_neg_i = -r_s1_i;
    assign w_shamt = r_s1_i[c_iw-1] ? w_neg_i : r_s1_i;
    assign w_m_ext = c_sw'(r_s1_m);
    assign w_sh    = r_s1_i[c_iw-1] ? (w_m_ext >> w_shamt) : (w_m_ext << w_shamt);
    // The guard bit can only be set when the exponent is already saturating
    assign w_sat   = (r_s1_i >= c_sat_i) | w_sh[OUT_W];
    assign w_uflow = (r_s1_i <= c_uflow_i);

    logic             r_s2_valid;
    logic [OUT_W-1:0] r_s2_sh;
    logic             r_s2_sat;
    logic             r_s2_uflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sh    <= '0;
            r_s2_sat   <= 1'b0;
            r_s2_uflow <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sh    <= w_sh[OUT_W-1:0];
            r_s2_sat   <= w_sat;
            r_s2_uflow <= w_uflow;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: output select and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_uflow <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_s2_valid;
            if (!r_s2_valid) begin
                out_data  <= '0;
                out_sat   <= 1'b0;
                out_uflow <= 1'b0;
            end else if (r_s2_sat) begin
                out_data  <= c_max;
                out_sat   <= 1'b1;
                out_uflow <= 1'b0;
            end else if (r_s2_uflow) begin
                out_data  <= '0;
                out_sat   <= 1'b0;
                out_uflow <= 1'b1;
            end else begin
                out_data  <= r_s2_sh;
                out_sat   <= 1'b0;
                out_uflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
